// File: rtl/imem_port_arbiter.sv
// Shares one single-port synchronous instruction memory between the fetch unit and the loader/debug port.
// Fetch wins after STARVE_LIMIT lost contests; bad addresses are granted but never reach the memory.
module imem_port_arbiter #(
  parameter int DEPTH        = 1024,
  parameter int AW           = $clog2(DEPTH),
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fetch_req_i,
  input  logic [31:0]   fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [31:0]   fetch_rdata_o,
  output logic          fetch_err_o,
  input  logic          load_req_i,
  input  logic          load_we_i,
  input  logic [31:0]   load_addr_i,
  input  logic [31:0]   load_wdata_i,
  output logic          load_gnt_o,
  output logic          load_rvalid_o,
  output logic [31:0]   load_rdata_o,
  output logic          load_err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_e;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  logic [CW-1:0] starve_q, starve_d;
  logic          valid_q, valid_d;
  owner_e        owner_q, owner_d;
  logic          err_q, err_d;

  logic          fetch_gnt_s, load_gnt_s;
  logic [31:0]   sel_addr_s;
  logic          sel_bad_s;
  logic          sel_write_s;

  // Fixed priority to the loader, overridden once fetch has lost STARVE_LIMIT contests in a row
  always_comb begin
    fetch_gnt_s = 1'b0;
    load_gnt_s  = 1'b0;
    starve_d    = '0;
    if (rst_i) begin
      starve_d = '0;
    end else if (fetch_req_i && load_req_i) begin
      if (starve_q < LIMIT_C) begin
        load_gnt_s = 1'b1;
        starve_d   = starve_q + CW'(1);
      end else begin
        fetch_gnt_s = 1'b1;
        starve_d    = '0;
      end
    end else if (fetch_req_i) begin
      fetch_gnt_s = 1'b1;
    end else if (load_req_i) begin
      load_gnt_s = 1'b1;
    end else begin
      starve_d = '0;
    end
  end

  // Memory request for the granted port; a bad address suppresses the access entirely
  always_comb begin
    sel_addr_s  = fetch_gnt_s ? fetch_addr_i : load_addr_i;
    sel_bad_s   = addr_bad(sel_addr_s);
    sel_write_s = load_gnt_s && load_we_i;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;
    if ((fetch_gnt_s || load_gnt_s) && !sel_bad_s) begin
      mem_en_o   = 1'b1;
      mem_addr_o = sel_addr_s[AW+1:2];
      if (sel_write_s) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = load_wdata_i;
      end else begin
        mem_we_o    = 1'b0;
        mem_wdata_o = 32'd0;
      end
    end else begin
      mem_en_o = 1'b0;
    end
  end

  assign fetch_gnt_o = fetch_gnt_s;
  assign load_gnt_o  = load_gnt_s;

  assign valid_d = fetch_gnt_s || (load_gnt_s && !load_we_i);
  assign owner_d = load_gnt_s ? OWN_LOAD : OWN_FETCH;
  assign err_d   = sel_bad_s;

  // Starvation counter and the one-deep tag of the read in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
      valid_q  <= 1'b0;
      owner_q  <= OWN_FETCH;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
    end
  end

  // Read return steering; rst masks a return that was in flight when reset arrived
  always_comb begin
    fetch_rvalid_o = 1'b0;
    fetch_rdata_o  = 32'd0;
    fetch_err_o    = 1'b0;
    load_rvalid_o  = 1'b0;
    load_rdata_o   = 32'd0;
    load_err_o     = load_gnt_s && load_we_i && sel_bad_s;
    if (valid_q && !rst_i) begin
      case (owner_q)
        OWN_FETCH: begin
          fetch_rvalid_o = 1'b1;
          fetch_rdata_o  = err_q ? 32'd0 : mem_rdata_i;
          fetch_err_o    = err_q;
        end
        OWN_LOAD: begin
          load_rvalid_o = 1'b1;
          load_rdata_o  = err_q ? 32'd0 : mem_rdata_i;
          load_err_o    = err_q || (load_gnt_s && load_we_i && sel_bad_s);
        end
        default: begin
          fetch_rvalid_o = 1'b0;
          load_rvalid_o  = 1'b0;
        end
      endcase
    end else begin
      fetch_rvalid_o = 1'b0;
      load_rvalid_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter: a cycle-level reference model with a shadow memory
// predicts grants, memory requests and read returns from the arbitration and decode rules.
module tb_imem_port_arbiter;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LIM   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, load_req, load_we;
  logic [31:0]   fetch_addr, load_addr, load_wdata;
  logic          fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0]   fetch_rdata;
  logic          load_gnt, load_rvalid, load_err;
  logic [31:0]   load_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata), .fetch_err_o(fetch_err),
    .load_req_i(load_req), .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .load_gnt_o(load_gnt), .load_rvalid_o(load_rvalid), .load_rdata_o(load_rdata), .load_err_o(load_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h0062E233;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Synchronous memory macro: writes land at the edge, reads return the next cycle
  bit [31:0] mem_val [DEPTH];
  bit        mem_wr  [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_val[mem_addr] <= mem_wdata;
        mem_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= mem_wr[mem_addr] ? mem_val[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          lose = 0;
  bit          pv = 1'b0;
  bit          po = 1'b0;
  bit          pe = 1'b0;
  logic [31:0] pd = 32'd0;
  logic [31:0] shadow [DEPTH];

  task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                      input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld);
    bit gf, gl, bad, wr, en, we, f_rv, l_rv, l_er;
    logic [31:0] a, wa;
    longint widx;
    rst = r; fetch_req = fr; fetch_addr = fa;
    load_req = lr; load_we = lw; load_addr = la; load_wdata = ld;
    #1;
    gf = 1'b0; gl = 1'b0;
    if (!r) begin
      if (fr && lr) begin
        if (lose < LIM) gl = 1'b1;
        else gf = 1'b1;
      end else if (fr) gf = 1'b1;
      else if (lr) gl = 1'b1;
    end
    a    = gf ? fa : la;
    widx = longint'(a) / 4;
    bad  = (longint'(a) % 4 != 0) || (widx >= DEPTH);
    wr   = gl && lw;
    en   = (gf || gl) && !bad;
    we   = en && wr;
    wa   = en ? 32'(widx) : 32'd0;
    f_rv = !r && pv && !po;
    l_rv = !r && pv && po;
    l_er = (l_rv && pe) || (gl && lw && bad);

    chk("fetch_gnt", fetch_gnt, gf);
    chk("load_gnt", load_gnt, gl);
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, wa);
    if (!en || we) chk("mem_wdata", mem_wdata, we ? ld : 32'd0);
    chk("fetch_rvalid", fetch_rvalid, f_rv);
    chk("fetch_rdata", fetch_rdata, f_rv ? pd : 32'd0);
    chk("fetch_err", fetch_err, f_rv && pe);
    chk("load_rvalid", load_rvalid, l_rv);
    chk("load_rdata", load_rdata, l_rv ? pd : 32'd0);
    chk("load_err", load_err, l_er);

    if (r) begin
      lose = 0;
      pv   = 1'b0;
    end else begin
      if (fr && lr && gl) lose = lose + 1;
      else lose = 0;
      pv = (gf || gl) && !wr;
      po = gl;
      pe = bad;
      pd = (bad || !pv) ? 32'd0 : shadow[int'(widx)];
      if (we) shadow[int'(widx)] = ld;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 31)) * 32'd4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 15) == 0) a = a | ($urandom() & 32'hFFFF_F000) | 32'h0000_1000;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = 32'd0;
    load_req = 1'b0; load_we = 1'b0; load_addr = 32'd0; load_wdata = 32'd0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Basic fetch of word 2
    step(0, 1, 32'h8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Write then read back the same word
    step(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    step(0, 0, 0, 1, 0, 32'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Continuous contention: L,L,L,L,F repeating
    for (int i = 0; i < 10; i++) step(0, 1, 32'h20, 1, 0, 32'h24, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Misaligned and out-of-range fetches
    step(0, 1, 32'h6, 0, 0, 0, 0);
    step(0, 1, 32'h1000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Reset arriving while a read is in flight
    step(0, 1, 32'h8, 0, 0, 0, 0);
    step(1, 1, 32'h8, 1, 0, 32'h8, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Bad write and bad read at 0x4000
    step(0, 0, 0, 1, 1, 32'h4000, 32'h12345678);
    step(0, 0, 0, 1, 0, 32'h4000, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0, rand_addr(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
